// File: rtl/moore_seq_pkg.sv
// Shared encodings and limits for the serial pattern detector.
// Optional match counter is built only when MOORE_SEQ_MATCH_CNT_EN is defined.
package moore_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_HUNT  = 2'b01;
  localparam logic [1:0] ST_MATCH = 2'b10;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

  // Width needed to hold a matched-prefix length 0..pat_w.
  function automatic int prog_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Serial-stream and result bundle of the pattern detector.
// master = stimulus side, slave = detector side.
interface moore_seq_detector_if
  import moore_seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int PW = prog_w(PAT_W);

  logic             en;
  logic             din;
  logic             load;
  logic [PAT_W-1:0] pattern_in;
  logic             overlap;
  logic             dout;
  logic [PW-1:0]    progress;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, din, load, pattern_in, overlap,
    input  dout, progress, match_cnt
  );

  modport slave (
    input  en, din, load, pattern_in, overlap,
    output dout, progress, match_cnt
  );

endinterface

// File: rtl/moore_seq_prefix_match.sv
// Longest suffix of hist_i that equals a prefix of pattern_i, capped at k_i+1 bits.
module moore_seq_prefix_match
  import moore_seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int PW    = prog_w(PAT_W)
) (
  input  logic [PAT_W-1:0] hist_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [PW-1:0]    k_i,
  output logic [PW-1:0]    j_o
);

  logic [PAT_W:1] hit_s;

  for (genvar gj = 1; gj <= PAT_W; gj++) begin : g_len
    assign hit_s[gj] = (hist_i[gj-1:0] == pattern_i[PAT_W-1 -: gj]) &&
                       (int'(k_i) >= gj - 1);
  end

  // Pick the longest candidate length that still matches.
  always_comb begin
    j_o = '0;
    for (int i = 1; i <= PAT_W; i++) begin
      j_o = hit_s[i] ? PW'(i) : j_o;
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with programmable pattern and overlap mode.
// Match counter present only when MOORE_SEQ_MATCH_CNT_EN is defined.
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
  parameter int               CNT_W   = 8
) (
  input logic                 clk,
  input logic                 rst,
  moore_seq_detector_if.slave bus
);

  localparam int PW = prog_w(PAT_W);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
    $error("moore_seq_detector: PAT_W or CNT_W out of range");
  end

  logic [1:0]       state_q,   state_d;
  logic [PW-1:0]    progress_q, progress_d;
  logic [PAT_W-1:0] hist_q,    hist_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] hist_shift_s;
  logic [PW-1:0]    k_s;
  logic [PW-1:0]    j_s;
  logic             restart_s;

  // Non-overlapping restart: forget history, search again from the new bit alone.
  assign restart_s    = (state_q == ST_MATCH) && !bus.overlap;
  assign hist_shift_s = restart_s ? {{(PAT_W-1){1'b0}}, bus.din}
                                  : {hist_q[PAT_W-2:0], bus.din};
  assign k_s          = restart_s ? '0 : progress_q;

  moore_seq_prefix_match #(.PAT_W(PAT_W), .PW(PW)) u_prefix (
    .hist_i    (hist_shift_s),
    .pattern_i (pattern_q),
    .k_i       (k_s),
    .j_o       (j_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      progress_q <= '0;
      hist_q     <= '0;
      pattern_q  <= PAT_RST;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      hist_q     <= hist_d;
      pattern_q  <= pattern_d;
    end
  end

  // Next-state decoder; load overrides everything else.
  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    hist_d     = hist_q;
    pattern_d  = pattern_q;
    case (state_q)
      ST_IDLE: begin
        state_d    = ST_HUNT;
        progress_d = '0;
        hist_d     = '0;
      end
      ST_HUNT, ST_MATCH: begin
        if (bus.en) begin
          hist_d     = hist_shift_s;
          progress_d = j_s;
          state_d    = (j_s == PW'(PAT_W)) ? ST_MATCH : ST_HUNT;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        progress_d = '0;
        hist_d     = '0;
      end
    endcase
    if (bus.load) begin
      pattern_d  = bus.pattern_in;
      hist_d     = '0;
      state_d    = ST_HUNT;
      progress_d = '0;
    end else begin
      pattern_d  = pattern_q;
    end
  end

  // Output decoder: driven from registered state only.
  always_comb begin
    bus.dout     = (state_q == ST_MATCH);
    bus.progress = progress_q;
  end

`ifdef MOORE_SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A sampled transition into MATCH is the only way state_d is MATCH while en=1.
  always_comb begin
    if (state_d == ST_MATCH && bus.en && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Match counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif

endmodule
